prompt_correlator: RTL



---
 rtl/prompt_correlator_if.sv | 30 +++
 rtl/prompt_correlator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/prompt_correlator_if.sv
// Sample-in / dump-out bundle for prompt_correlator.
// master = generator + tracking-loop side, slave = the correlator.
interface prompt_correlator_if #(
  parameter int SAMPLE_WIDTH = 3,
  parameter int ACC_WIDTH    = 16,
  parameter int CNT_WIDTH    = 16
);
  logic                           clear;
  logic                           sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] i_sample;
  logic signed [SAMPLE_WIDTH-1:0] q_sample;
  logic                           ca_bit;
  logic [9:0]                     code_shift;
  logic signed [ACC_WIDTH-1:0]    dump_i;
  logic signed [ACC_WIDTH-1:0]    dump_q;
  logic [CNT_WIDTH-1:0]           dump_count;
  logic                           dump_valid;
  logic                           dump_ready;
  logic                           overrun;

  modport master (
    output clear, sample_valid, i_sample, q_sample, ca_bit, code_shift, dump_ready,
    input  dump_i, dump_q, dump_count, dump_valid, overrun
  );

  modport slave (
    input  clear, sample_valid, i_sample, q_sample, ca_bit, code_shift, dump_ready,
    output dump_i, dump_q, dump_count, dump_valid, overrun
  );
endinterface

// File: rtl/prompt_correlator.sv
// Prompt correlator: despreads I/Q by the C/A chip, accumulates one code period, dumps at each epoch.
// Optional macro CORR_SATURATE_EN: saturating accumulator adds (default: two's-complement wrap).
module prompt_correlator #(
  parameter int SAMPLE_WIDTH = 3,
  parameter int ACC_WIDTH    = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  prompt_correlator_if.slave   bus
);

  typedef enum logic {ST_WAIT, ST_ACCUM} state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] dump_i_q, dump_i_d;
  logic signed [ACC_WIDTH-1:0] dump_q_q, dump_q_d;
  logic [CNT_WIDTH-1:0]        dump_count_q, dump_count_d;
  logic                        dump_valid_q, dump_valid_d;
  logic                        overrun_q, overrun_d;
  logic                        prev_nz_q, prev_nz_d;
  logic                        seen_q, seen_d;

  logic signed [ACC_WIDTH-1:0] prod_i, prod_q;
  logic                        boundary;

  function automatic logic signed [ACC_WIDTH-1:0] chip_prod(
    input logic signed [SAMPLE_WIDTH-1:0] s,
    input logic                           neg
  );
    logic signed [ACC_WIDTH-1:0] ext;
    ext = {{(ACC_WIDTH-SAMPLE_WIDTH){s[SAMPLE_WIDTH-1]}}, s};
    return neg ? -ext : ext;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] sum;
    sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
`ifdef CORR_SATURATE_EN
    // Extra top bit disagreeing with the sign bit means the signed add overflowed.
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      return sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
`endif
    return sum[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + 1'b1;
  endfunction

  always_comb begin
    prod_i   = chip_prod(bus.i_sample, bus.ca_bit);
    prod_q   = chip_prod(bus.q_sample, bus.ca_bit);
    // An epoch is a phase-0 chip following a nonzero phase, or the very first phase-0 chip after re-arm.
    boundary = (bus.code_shift == 10'd0) && (prev_nz_q || !seen_q);
  end

  always_comb begin
    state_d      = state_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    cnt_d        = cnt_q;
    dump_i_d     = dump_i_q;
    dump_q_d     = dump_q_q;
    dump_count_d = dump_count_q;
    dump_valid_d = dump_valid_q;
    overrun_d    = overrun_q;
    prev_nz_d    = prev_nz_q;
    seen_d       = seen_q;

    if (dump_valid_q && bus.dump_ready) begin
      dump_valid_d = 1'b0;
    end

    if (bus.clear) begin
      state_d      = ST_WAIT;
      acc_i_d      = '0;
      acc_q_d      = '0;
      cnt_d        = '0;
      dump_valid_d = 1'b0;
      overrun_d    = 1'b0;
      prev_nz_d    = 1'b0;
      seen_d       = 1'b0;
    end else if (bus.sample_valid) begin
      prev_nz_d = (bus.code_shift != 10'd0);
      seen_d    = 1'b1;
      case (state_q)
        ST_WAIT: begin
          if (boundary) begin
            state_d = ST_ACCUM;
            acc_i_d = prod_i;
            acc_q_d = prod_q;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
        ST_ACCUM: begin
          if (boundary) begin
            dump_i_d     = acc_i_q;
            dump_q_d     = acc_q_q;
            dump_count_d = cnt_q;
            dump_valid_d = 1'b1;
            if (dump_valid_q && !bus.dump_ready) begin
              overrun_d = 1'b1;
            end
            acc_i_d = prod_i;
            acc_q_d = prod_q;
            cnt_d   = CNT_WIDTH'(1);
          end else begin
            acc_i_d = acc_add(acc_i_q, prod_i);
            acc_q_d = acc_add(acc_q_q, prod_q);
            cnt_d   = cnt_inc(cnt_q);
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      cnt_q        <= '0;
      dump_i_q     <= '0;
      dump_q_q     <= '0;
      dump_count_q <= '0;
      dump_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      prev_nz_q    <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      cnt_q        <= cnt_d;
      dump_i_q     <= dump_i_d;
      dump_q_q     <= dump_q_d;
      dump_count_q <= dump_count_d;
      dump_valid_q <= dump_valid_d;
      overrun_q    <= overrun_d;
      prev_nz_q    <= prev_nz_d;
      seen_q       <= seen_d;
    end
  end

  assign bus.dump_i     = dump_i_q;
  assign bus.dump_q     = dump_q_q;
  assign bus.dump_count = dump_count_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.overrun    = overrun_q;

endmodule
